// File: rtl/matrix_add_pipe_pkg.sv
// Shared definitions for the pipelined matrix adder: op encodings and
// saturation bound helper.
package matadd_pkg;

    localparam logic MATADD_OP_ADD = 1'b0;
    localparam logic MATADD_OP_SUB = 1'b1;

    typedef struct packed {
        logic [63:0] min_v;
        logic [63:0] max_v;
    } sat_bounds_t;

    // Two's complement min/max bit patterns for a signed value of 'width' bits,
    // returned in the low 'width' bits of each field.
    function automatic sat_bounds_t sat_clamp(input int unsigned width);
        sat_bounds_t bounds;
        bounds.min_v = 64'd1 << (width - 32'd1);
        bounds.max_v = bounds.min_v - 64'd1;
        return bounds;
    endfunction

endpackage

// File: rtl/matrix_add_pipe_if.sv
// Operand and result valid/ready streams of the matrix adder.
interface matrix_add_pipe_if #(
    parameter int PARALLEL_NUM = 28,
    parameter int DATA_W       = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_op;
    logic [PARALLEL_NUM*DATA_W-1:0] in_a;
    logic [PARALLEL_NUM*DATA_W-1:0] in_b;
    logic                           out_valid;
    logic                           out_ready;
    logic [PARALLEL_NUM*DATA_W-1:0] out_res;
    logic [PARALLEL_NUM-1:0]        out_sat;
    logic                           out_last;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_sat, out_last
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_sat, out_last
    );
endinterface

// File: rtl/matrix_add_pipe_lane.sv
// One lane of the adder: add/sub with optional signed saturation
// (enabled by MATADD_SAT_EN).
module matadd_lane
    import matadd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              op_i,
    output logic [DATA_W-1:0] res_o,
    output logic              sat_o
);

    logic              sub_s;
    logic [DATA_W-1:0] b_eff_s;
    logic [DATA_W-1:0] sum_s;

    // Subtraction as a + ~b + 1 so a single adder serves both ops.
    assign sub_s   = (op_i == MATADD_OP_SUB);
    assign b_eff_s = sub_s ? ~b_i : b_i;
    assign sum_s   = a_i + b_eff_s + {{(DATA_W-1){1'b0}}, sub_s};

`ifdef MATADD_SAT_EN
    localparam sat_bounds_t BOUNDS = sat_clamp(DATA_W);

    logic ovf_s;

    // Overflow: both adder inputs share a sign that the sum does not.
    assign ovf_s = (a_i[DATA_W-1] == b_eff_s[DATA_W-1]) &&
                   (sum_s[DATA_W-1] != a_i[DATA_W-1]);
    assign res_o = ovf_s ? (a_i[DATA_W-1] ? BOUNDS.min_v[DATA_W-1:0]
                                          : BOUNDS.max_v[DATA_W-1:0])
                         : sum_s;
    assign sat_o = ovf_s;
`else
    assign res_o = sum_s;
    assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/matrix_add_pipe.sv
// Two-stage valid/ready pipelined matrix adder with tile last-beat tagging.
// Optional signed saturation is selected with the MATADD_SAT_EN macro.
module matrix_add_pipe
    import matadd_pkg::*;
#(
    parameter int PARALLEL_NUM   = 28,
    parameter int DATA_W         = 16,
    parameter int BEATS_PER_TILE = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_add_pipe_if.slave   io
);

    localparam int BUS_W = PARALLEL_NUM * DATA_W;
    localparam int CNT_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_TILE - 1);

    logic                    s1_valid_q;
    logic                    s1_op_q;
    logic [BUS_W-1:0]        s1_a_q;
    logic [BUS_W-1:0]        s1_b_q;
    logic                    s1_last_q;
    logic                    s2_valid_q;
    logic [BUS_W-1:0]        s2_res_q;
    logic [PARALLEL_NUM-1:0] s2_sat_q;
    logic                    s2_last_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [CNT_W-1:0]        beat_cnt_d;

    logic                    s1_adv_s;
    logic                    s2_adv_s;
    logic                    in_xfer_s;
    logic                    last_beat_s;
    logic [BUS_W-1:0]        lane_res_s;
    logic [PARALLEL_NUM-1:0] lane_sat_s;

    // in_ready depends combinationally on out_ready so a full pipe can still
    // accept while it drains.
    assign s2_adv_s    = !s2_valid_q || io.out_ready;
    assign s1_adv_s    = !s1_valid_q || s2_adv_s;
    assign in_xfer_s   = io.in_valid && s1_adv_s;
    assign last_beat_s = (beat_cnt_q == LAST_CNT);

    // Tile beat counter next state.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (in_xfer_s) begin
            if (last_beat_s) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Tile beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_last_q  <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_q <= io.in_valid;
            if (io.in_valid) begin
                s1_op_q   <= io.in_op;
                s1_a_q    <= io.in_a;
                s1_b_q    <= io.in_b;
                s1_last_q <= last_beat_s;
            end
        end
    end

    for (genvar i = 0; i < PARALLEL_NUM; i++) begin : g_lane
        matadd_lane #(.DATA_W(DATA_W)) u_lane (
            .a_i   (s1_a_q[i*DATA_W +: DATA_W]),
            .b_i   (s1_b_q[i*DATA_W +: DATA_W]),
            .op_i  (s1_op_q),
            .res_o (lane_res_s[i*DATA_W +: DATA_W]),
            .sat_o (lane_sat_s[i])
        );
    end

    // Stage 2: result capture; fields only move when S1 holds a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_sat_q   <= '0;
            s2_last_q  <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q  <= lane_res_s;
                s2_sat_q  <= lane_sat_s;
                s2_last_q <= s1_last_q;
            end
        end
    end

    assign io.in_ready  = s1_adv_s;
    assign io.out_valid = s2_valid_q;
    assign io.out_res   = s2_res_q;
    assign io.out_sat   = s2_sat_q;
    assign io.out_last  = s2_last_q;

endmodule
